alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one ALU operation per request (two ALU cycles for funnel shift) and returns a held response
// Ports:
//   clk_i, rst_i                    clock, async active-high reset
//   req_valid_i/req_ready_o         request handshake; req_op_i, req_a_i, req_b_i, req_c_i operator and operands
//   alu_*_o / alu_*_i               drive an external ALU and take back its result and comparison bit
//   rsp_valid_o/rsp_ready_i         response handshake; rsp_result_o, rsp_cmp_o, rsp_illegal_o response payload
//   retired_cnt_o                   count of completed response handshakes (wraps)
package ibex_pkg;
  typedef enum logic [6:0] {
    ALU_ADD = 7'd0,
    ALU_SUB = 7'd1,
    ALU_XOR = 7'd2,
    ALU_OR  = 7'd3,
    ALU_AND = 7'd4,
    ALU_SRA = 7'd8,
    ALU_SRL = 7'd9,
    ALU_SLL = 7'd10,
    ALU_LT  = 7'd25,
    ALU_LTU = 7'd26,
    ALU_GE  = 7'd27,
    ALU_GEU = 7'd28,
    ALU_EQ  = 7'd29,
    ALU_NE  = 7'd30,
    ALU_FSL = 7'd40,
    ALU_FSR = 7'd41
  } alu_op_e;
endpackage

module alu_sequencer #(
  parameter bit MultiCycleFsl = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  ibex_pkg::alu_op_e  req_op_i,
  input  logic [31:0]        req_a_i,
  input  logic [31:0]        req_b_i,
  input  logic [31:0]        req_c_i,
  output ibex_pkg::alu_op_e  alu_operator_o,
  output logic [31:0]        alu_operand_a_o,
  output logic [31:0]        alu_operand_b_o,
  output logic               alu_instr_first_cycle_o,
  input  logic [31:0]        alu_result_i,
  input  logic               alu_comparison_result_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [31:0]        rsp_result_o,
  output logic               rsp_cmp_o,
  output logic               rsp_illegal_o,
  output logic [15:0]        retired_cnt_o
);
  import ibex_pkg::*;
  typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, RESP} state_e;
  state_e      state_q, state_d;
  alu_op_e     op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d, imd_q, imd_d, res_q, res_d;
  logic        cmp_q, cmp_d, ill_q, ill_d;
  logic [15:0] cnt_q, cnt_d;
  logic        accept, retire, legal, two_cycle;
  assign legal     = op_q inside {ALU_AND, ALU_ADD, ALU_SLL, ALU_SRL, ALU_GE, ALU_FSL};
  assign two_cycle = MultiCycleFsl && (op_q == ALU_FSL);
  assign retire    = (state_q == RESP) && rsp_ready_i;
  // ready in RESP follows rsp_ready_i so a new request can be taken on the handshake edge
  assign req_ready_o = (state_q == IDLE) || retire;
  assign accept      = req_valid_i && req_ready_o;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= ALU_ADD;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      c_q     <= 32'h0;
      imd_q   <= 32'h0;
      res_q   <= 32'h0;
      cmp_q   <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      imd_q   <= imd_d;
      res_q   <= res_d;
      cmp_q   <= cmp_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? EXEC1 : IDLE;
      EXEC1:   state_d = two_cycle ? EXEC2 : RESP;
      EXEC2:   state_d = RESP;
      RESP:    state_d = retire ? (accept ? EXEC1 : IDLE) : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    op_d  = accept ? req_op_i : op_q;
    a_d   = accept ? req_a_i : a_q;
    b_d   = accept ? req_b_i : b_q;
    c_d   = accept ? req_c_i : c_q;
    imd_d = (state_q == EXEC1 && two_cycle) ? alu_result_i : imd_q;
    res_d = res_q;
    cmp_d = cmp_q;
    ill_d = ill_q;
    // illegal operators finish in one cycle with a zeroed payload
    if (state_q == EXEC1 && !two_cycle) begin
      res_d = legal ? alu_result_i : 32'h0;
      cmp_d = legal && alu_comparison_result_i;
      ill_d = !legal;
    end else if (state_q == EXEC2) begin
      res_d = imd_q | alu_result_i;
      cmp_d = alu_comparison_result_i;
      ill_d = 1'b0;
    end
    cnt_d = retire ? cnt_q + 16'd1 : cnt_q;
  end
  always_comb begin
    alu_operator_o          = (state_q == EXEC1) ? op_q : (state_q == EXEC2) ? ALU_FSL : ALU_ADD;
    alu_operand_a_o         = (state_q == EXEC1) ? a_q : (state_q == EXEC2) ? c_q : 32'h0;
    alu_operand_b_o         = (state_q == EXEC1 || state_q == EXEC2) ? b_q : 32'h0;
    alu_instr_first_cycle_o = (state_q == EXEC1);
    rsp_valid_o             = (state_q == RESP);
    rsp_result_o            = res_q;
    rsp_cmp_o               = cmp_q;
    rsp_illegal_o           = ill_q;
    retired_cnt_o           = cnt_q;
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural ALU attached
module tb_alu_sequencer;
  import ibex_pkg::*;
  logic        clk = 1'b0, rst_i = 1'b1;
  logic        req_valid = 1'b0, rsp_ready = 1'b1;
  alu_op_e     req_op = ALU_ADD;
  logic [31:0] req_a = '0, req_b = '0, req_c = '0;
  logic        req_ready_o, alu_first, rsp_valid_o, rsp_cmp_o, rsp_illegal_o, alu_cmp_in;
  alu_op_e     alu_operator;
  logic [31:0] alu_a, alu_b, alu_result_in, rsp_result_o;
  logic [15:0] retired_cnt_o;
  typedef struct packed {logic [31:0] r; logic c; logic il;} exp_t;
  exp_t        sb[$];
  int          errors = 0, checks = 0;
  logic [15:0] exp_cnt = 16'h0;

  always #5 clk = ~clk;

  alu_sequencer #(.MultiCycleFsl(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c),
    .alu_operator_o(alu_operator), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
    .alu_instr_first_cycle_o(alu_first), .alu_result_i(alu_result_in),
    .alu_comparison_result_i(alu_cmp_in), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result_o), .rsp_cmp_o(rsp_cmp_o), .rsp_illegal_o(rsp_illegal_o),
    .retired_cnt_o(retired_cnt_o)
  );

  function automatic logic is_legal(alu_op_e op);
    return op inside {ALU_AND, ALU_ADD, ALU_SLL, ALU_SRL, ALU_GE, ALU_FSL};
  endfunction

  // behavioural ALU: FSL first cycle shifts A left, second cycle brings in the top bits of C
  function automatic logic [31:0] alu_res(alu_op_e op, logic [31:0] a, logic [31:0] b, logic first);
    case (op)
      ALU_ADD: return a + b;
      ALU_AND: return a & b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_GE:  return {31'b0, $signed(a) >= $signed(b)};
      ALU_FSL: return first ? a << b[4:0] : (b[4:0] == 5'd0 ? 32'h0 : a >> (6'd32 - {1'b0, b[4:0]}));
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic alu_cmp(alu_op_e op, logic [31:0] a, logic [31:0] b);
    return (op == ALU_GE) ? ($signed(a) >= $signed(b)) : !is_legal(op);
  endfunction

  assign alu_result_in = alu_res(alu_operator, alu_a, alu_b, alu_first);
  assign alu_cmp_in    = alu_cmp(alu_operator, alu_a, alu_b);

  function automatic exp_t exp_of(alu_op_e op, logic [31:0] a, logic [31:0] b, logic [31:0] c);
    exp_t e;
    e.il = !is_legal(op);
    e.r  = e.il ? 32'h0 : (op == ALU_FSL) ? (alu_res(op, a, b, 1'b1) | alu_res(op, c, b, 1'b0)) : alu_res(op, a, b, 1'b1);
    e.c  = e.il ? 1'b0 : alu_cmp(op, a, b);
    return e;
  endfunction

  // called at a negedge; returns at the negedge right after the accepting edge (DUT in EXEC1)
  task automatic send(input alu_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_c = c;
    while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL send_ready: got %b want 1 within 20 cycles", req_ready_o); end
    sb.push_back(exp_of(op, a, b, c));
    @(negedge clk);
    req_valid = 1'b0; req_op = ALU_SUB; req_a = 32'hBAD0_BAD0; req_b = 32'h3F; req_c = '1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", rsp_valid_o); end
    checks++; if (rsp_result_o !== 32'h0 || rsp_cmp_o !== 1'b0 || rsp_illegal_o !== 1'b0) begin errors++; $display("FAIL rst_payload: got %h/%b/%b want 0/0/0", rsp_result_o, rsp_cmp_o, rsp_illegal_o); end
    checks++; if (retired_cnt_o !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h want 0000", retired_cnt_o); end
    checks++; if (req_ready_o !== 1'b1 || alu_operator !== ALU_ADD || alu_a !== 32'h0 || alu_first !== 1'b0) begin errors++; $display("FAIL rst_idle: got ready=%b op=%h a=%h first=%b want 1/00/0/0", req_ready_o, alu_operator, alu_a, alu_first); end
    rst_i = 1'b0;
  endtask

  task automatic test_add;
    exp_t e;
    send(ALU_ADD, 32'd5, 32'd7, 32'd0);
    checks++; if (alu_operator !== ALU_ADD || alu_a !== 32'd5 || alu_b !== 32'd7 || alu_first !== 1'b1) begin errors++; $display("FAIL add_exec1: got op=%h a=%h b=%h first=%b want 00/5/7/1", alu_operator, alu_a, alu_b, alu_first); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL add_early: got %b want 0", rsp_valid_o); end
    @(negedge clk);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'd12) begin errors++; $display("FAIL add_rsp: got v=%b r=%h want 1/0000000c", rsp_valid_o, rsp_result_o); end
    e = sb.pop_front();
    checks++; if (rsp_result_o !== e.r || rsp_cmp_o !== e.c || rsp_illegal_o !== e.il) begin errors++; $display("FAIL add_sb: got %h/%b/%b want %h/%b/%b", rsp_result_o, rsp_cmp_o, rsp_illegal_o, e.r, e.c, e.il); end
    exp_cnt++;
    @(negedge clk);
    checks++; if (retired_cnt_o !== exp_cnt || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL add_retire: got cnt=%h v=%b want %h/0", retired_cnt_o, rsp_valid_o, exp_cnt); end
  endtask

  task automatic test_fsl;
    exp_t e;
    send(ALU_FSL, 32'h8000_0001, 32'd4, 32'hF000_0000);
    checks++; if (alu_first !== 1'b1 || alu_operator !== ALU_FSL || alu_a !== 32'h8000_0001) begin errors++; $display("FAIL fsl_exec1: got first=%b op=%h a=%h want 1/28/80000001", alu_first, alu_operator, alu_a); end
    @(negedge clk);
    checks++; if (alu_first !== 1'b0 || alu_operator !== ALU_FSL || alu_a !== 32'hF000_0000 || alu_b !== 32'd4) begin errors++; $display("FAIL fsl_exec2: got first=%b op=%h a=%h b=%h want 0/28/f0000000/4", alu_first, alu_operator, alu_a, alu_b); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL fsl_early: got %b want 0", rsp_valid_o); end
    @(negedge clk);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'h0000_001F) begin errors++; $display("FAIL fsl_rsp: got v=%b r=%h want 1/0000001f", rsp_valid_o, rsp_result_o); end
    e = sb.pop_front();
    checks++; if (rsp_result_o !== e.r || rsp_cmp_o !== e.c || rsp_illegal_o !== e.il) begin errors++; $display("FAIL fsl_sb: got %h/%b/%b want %h/%b/%b", rsp_result_o, rsp_cmp_o, rsp_illegal_o, e.r, e.c, e.il); end
    exp_cnt++;
    @(negedge clk);
    checks++; if (retired_cnt_o !== exp_cnt) begin errors++; $display("FAIL fsl_cnt: got %h want %h", retired_cnt_o, exp_cnt); end
  endtask

  task automatic test_ge_stall;
    exp_t e;
    rsp_ready = 1'b0;
    send(ALU_GE, 32'hFFFF_FFFF, 32'd1, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid_o !== 1'b1 || rsp_cmp_o !== 1'b0 || rsp_result_o !== 32'h0 || req_ready_o !== 1'b0) begin errors++; $display("FAIL ge_hold%0d: got v=%b c=%b r=%h rdy=%b want 1/0/0/0", i, rsp_valid_o, rsp_cmp_o, rsp_result_o, req_ready_o); end
      req_a = $urandom; req_b = $urandom;
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++; if (rsp_result_o !== e.r || rsp_cmp_o !== e.c || rsp_illegal_o !== e.il) begin errors++; $display("FAIL ge_sb: got %h/%b/%b want %h/%b/%b", rsp_result_o, rsp_cmp_o, rsp_illegal_o, e.r, e.c, e.il); end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL ge_ready: got %b want 1", req_ready_o); end
    exp_cnt++;
    @(negedge clk);
    checks++; if (rsp_valid_o !== 1'b0 || retired_cnt_o !== exp_cnt) begin errors++; $display("FAIL ge_retire: got v=%b cnt=%h want 0/%h", rsp_valid_o, retired_cnt_o, exp_cnt); end
  endtask

  task automatic test_illegal;
    exp_t e;
    send(alu_op_e'(7'h7F), 32'd123, 32'd456, 32'd0);
    @(negedge clk);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_illegal_o !== 1'b1 || rsp_result_o !== 32'h0 || rsp_cmp_o !== 1'b0) begin errors++; $display("FAIL ill_rsp: got v=%b il=%b r=%h c=%b want 1/1/0/0", rsp_valid_o, rsp_illegal_o, rsp_result_o, rsp_cmp_o); end
    e = sb.pop_front();
    checks++; if (rsp_result_o !== e.r || rsp_cmp_o !== e.c || rsp_illegal_o !== e.il) begin errors++; $display("FAIL ill_sb: got %h/%b/%b want %h/%b/%b", rsp_result_o, rsp_cmp_o, rsp_illegal_o, e.r, e.c, e.il); end
    exp_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    alu_op_e     ops[3] = '{ALU_AND, ALU_SLL, ALU_SRL};
    logic [31:0] av[3]  = '{32'hF0F0_F0F0, 32'h0000_0001, 32'h8000_0000};
    logic [31:0] bv[3]  = '{32'hFF00_FF00, 32'h0000_0005, 32'h0000_0003};
    exp_t        e;
    req_valid = 1'b1; req_op = ops[0]; req_a = av[0]; req_b = bv[0];
    sb.push_back(exp_of(ops[0], av[0], bv[0], 32'h0));
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++; if (alu_first !== 1'b1 || alu_operator !== ops[i]) begin errors++; $display("FAIL b2b_exec%0d: got first=%b op=%h want 1/%h", i, alu_first, alu_operator, ops[i]); end
      @(negedge clk);
      checks++; if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_resp%0d: got v=%b rdy=%b want 1/1", i, rsp_valid_o, req_ready_o); end
      e = sb.pop_front();
      checks++; if (rsp_result_o !== e.r || rsp_cmp_o !== e.c || rsp_illegal_o !== e.il) begin errors++; $display("FAIL b2b_sb%0d: got %h/%b/%b want %h/%b/%b", i, rsp_result_o, rsp_cmp_o, rsp_illegal_o, e.r, e.c, e.il); end
      exp_cnt++;
      if (i < 2) begin
        req_op = ops[i+1]; req_a = av[i+1]; req_b = bv[i+1];
        sb.push_back(exp_of(ops[i+1], av[i+1], bv[i+1], 32'h0));
      end else req_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (rsp_valid_o !== 1'b0 || retired_cnt_o !== exp_cnt) begin errors++; $display("FAIL b2b_end: got v=%b cnt=%h want 0/%h", rsp_valid_o, retired_cnt_o, exp_cnt); end
  endtask

  task automatic test_reset_mid_exec2;
    logic seen = 1'b0;
    send(ALU_FSL, 32'h1234_5678, 32'd8, 32'hABCD_EF01);
    @(negedge clk);
    checks++; if (alu_first !== 1'b0 || alu_operator !== ALU_FSL) begin errors++; $display("FAIL rmid_exec2: got first=%b op=%h want 0/28", alu_first, alu_operator); end
    rst_i = 1'b1;
    #1;
    checks++; if (rsp_valid_o !== 1'b0 || rsp_result_o !== 32'h0 || rsp_cmp_o !== 1'b0 || rsp_illegal_o !== 1'b0) begin errors++; $display("FAIL rmid_async: got v=%b r=%h c=%b il=%b want 0/0/0/0", rsp_valid_o, rsp_result_o, rsp_cmp_o, rsp_illegal_o); end
    checks++; if (retired_cnt_o !== 16'h0 || req_ready_o !== 1'b1 || alu_operator !== ALU_ADD) begin errors++; $display("FAIL rmid_idle: got cnt=%h rdy=%b op=%h want 0000/1/00", retired_cnt_o, req_ready_o, alu_operator); end
    sb.delete();
    exp_cnt = 16'h0;
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen |= rsp_valid_o;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_norsp: got valid=%b after reset want 0", seen); end
  endtask

  task automatic test_wrap;
    exp_t e;
    force dut.cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.cnt_q;
    exp_cnt = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      send(ALU_ADD, 32'(i + 1), 32'd2, 32'd0);
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== e.r) begin errors++; $display("FAIL wrap_rsp%0d: got v=%b r=%h want 1/%h", i, rsp_valid_o, rsp_result_o, e.r); end
      exp_cnt++;
      @(negedge clk);
      checks++; if (retired_cnt_o !== exp_cnt) begin errors++; $display("FAIL wrap_cnt%0d: got %h want %h", i, retired_cnt_o, exp_cnt); end
    end
    checks++; if (retired_cnt_o !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", retired_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_fsl();
    test_ge_stall();
    test_illegal();
    test_back_to_back();
    test_reset_mid_exec2();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
